// File: rtl/instr_mem_pkg.sv
// Shared definitions for the pipelined instruction memory: fault bit
// positions, the default NOP encoding and the per-stage control record.
package instr_mem_pkg;

  localparam int FAULT_MISALIGN = 0;
  localparam int FAULT_RANGE    = 1;

  // addi x0, x0, 0 -- harmless filler returned for faulting fetches
  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef logic [1:0] fault_t;

  // Control half of a pipeline stage; the instruction word travels beside it
  // so its width can follow the XLEN parameter of the instantiating module.
  typedef struct packed {
    logic   valid;
    fault_t fault;
  } stage_ctl_t;

  // Packs the two decode conditions into a fault vector.
  function automatic fault_t make_fault(input logic misalign, input logic out_of_range);
    fault_t f;
    f = '0;
    f[FAULT_MISALIGN] = misalign;
    f[FAULT_RANGE]    = out_of_range;
    return f;
  endfunction

endpackage

// File: rtl/instr_mem_array.sv
// Synchronous-read, single-write instruction array. A read and a write to the
// same word on the same edge return the old contents (read-before-write).
module instr_mem_array #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 1280,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            rd_en,
  input  logic [AW-1:0]   rd_addr,
  output logic [XLEN-1:0] rd_data,
  input  logic            we,
  input  logic [AW-1:0]   wr_addr,
  input  logic [XLEN-1:0] wr_data
);

  // Contents start at zero and survive reset; only the read register resets.
  logic [XLEN-1:0] mem [DEPTH] = '{default: '0};

  // Program-load write; indices past the end of the array are dropped.
  always_ff @(posedge clk) begin
    if (we && (32'(wr_addr) < 32'(DEPTH))) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // Read register; holds its value when rd_en is low so a stalled stage 1
  // keeps presenting the same word.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_data <= '0;
    end else if (rd_en) begin
      rd_data <= mem[rd_addr];
    end
  end

endmodule

// File: rtl/instr_mem_pipelined.sv
// Pipelined instruction memory between fetch and decode.
//
// Handshake: a request transfers on a rising edge where req_valid && req_ready;
// a response transfers where rsp_valid && rsp_ready. While rsp_valid is high
// and rsp_ready is low the whole pipeline stalls, rsp_* hold steady and
// req_ready drops. req_ready is also low during flush so nothing is accepted
// in a flush cycle. req_ready never depends on req_valid.
module instr_mem_pipelined
  import instr_mem_pkg::*;
#(
  parameter int          XLEN         = 32,
  parameter int          DEPTH        = 1280,
  parameter int          READ_LATENCY = 1,
  parameter int          BYTE_ADDR    = 0,
  parameter logic [31:0] NOP_INSTR    = NOP
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic [XLEN-1:0]          req_addr,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [XLEN-1:0]          rsp_instr,
  output logic [1:0]               rsp_fault,
  input  logic                     flush,
  input  logic                     prog_we,
  input  logic [$clog2(DEPTH)-1:0] prog_addr,
  input  logic [XLEN-1:0]          prog_data
);

  localparam int AW = $clog2(DEPTH);

  logic            stall;
  logic            accept;
  logic [XLEN-1:0] word_idx;
  fault_t          req_fault;
  logic [XLEN-1:0] rd_data;
  stage_ctl_t      s1;
  logic [XLEN-1:0] s1_instr;

  assign stall     = rsp_valid && !rsp_ready;
  assign req_ready = !stall && !flush;
  assign accept    = req_valid && req_ready;
  assign word_idx  = (BYTE_ADDR != 0) ? (req_addr >> 2) : req_addr;

  // Decode the incoming address into misaligned / out-of-range flags.
  always_comb begin
    req_fault = make_fault((BYTE_ADDR != 0) && (req_addr[1:0] != 2'b00),
                           word_idx >= XLEN'(DEPTH));
  end

  // Out-of-range indices never reach the array; their word is replaced by NOP.
  instr_mem_array #(
    .XLEN  (XLEN),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_array (
    .clk     (clk),
    .reset   (reset),
    .rd_en   (!stall && !req_fault[FAULT_RANGE]),
    .rd_addr (word_idx[AW-1:0]),
    .rd_data (rd_data),
    .we      (prog_we),
    .wr_addr (prog_addr),
    .wr_data (prog_data)
  );

  // Stage 1 control: captured alongside the array read.
  always_ff @(posedge clk) begin
    if (reset) begin
      s1 <= '0;
    end else if (flush) begin
      s1.valid <= 1'b0;
    end else if (!stall) begin
      s1.valid <= accept;
      s1.fault <= req_fault;
    end
  end

  assign s1_instr = (s1.fault != 2'b00) ? NOP_INSTR[XLEN-1:0] : rd_data;

  if (READ_LATENCY == 1) begin : g_single
    assign rsp_valid = s1.valid;
    assign rsp_instr = s1_instr;
    assign rsp_fault = s1.fault;
  end else begin : g_multi
    localparam int N = READ_LATENCY - 1;

    stage_ctl_t      ctl [N];
    logic [XLEN-1:0] ins [N];

    // Stages 2..READ_LATENCY: plain shift register, frozen on stall.
    always_ff @(posedge clk) begin
      if (reset) begin
        for (int i = 0; i < N; i++) begin
          ctl[i] <= '0;
          ins[i] <= '0;
        end
      end else if (flush) begin
        for (int i = 0; i < N; i++) begin
          ctl[i].valid <= 1'b0;
        end
      end else if (!stall) begin
        ctl[0] <= s1;
        ins[0] <= s1_instr;
        for (int i = 1; i < N; i++) begin
          ctl[i] <= ctl[i-1];
          ins[i] <= ins[i-1];
        end
      end
    end

    assign rsp_valid = ctl[N-1].valid;
    assign rsp_instr = ins[N-1];
    assign rsp_fault = ctl[N-1].fault;
  end

endmodule

// File: tb/tb_instr_mem_pipelined.sv
// Directed bench for instr_mem_pipelined: one instance with byte addressing
// and latency 2, one with word addressing and latency 4.
module tb_instr_mem_pipelined;

  localparam int XLEN    = 32;
  localparam int A_DEPTH = 16;
  localparam int A_AW    = $clog2(A_DEPTH);
  localparam int B_DEPTH = 1280;
  localparam int B_AW    = $clog2(B_DEPTH);

  // Clock and reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            a_reset, a_req_valid, a_req_ready, a_rsp_valid, a_rsp_ready;
  logic            a_flush, a_prog_we;
  logic [XLEN-1:0] a_req_addr, a_rsp_instr, a_prog_data;
  logic [1:0]      a_rsp_fault;
  logic [A_AW-1:0] a_prog_addr;

  logic            b_reset, b_req_valid, b_req_ready, b_rsp_valid, b_rsp_ready;
  logic            b_flush, b_prog_we;
  logic [XLEN-1:0] b_req_addr, b_rsp_instr, b_prog_data;
  logic [1:0]      b_rsp_fault;
  logic [B_AW-1:0] b_prog_addr;

  instr_mem_pipelined #(
    .XLEN(XLEN), .DEPTH(A_DEPTH), .READ_LATENCY(2), .BYTE_ADDR(1), .NOP_INSTR(32'h0000_0013)
  ) dut_a (
    .clk(clk), .reset(a_reset),
    .req_valid(a_req_valid), .req_ready(a_req_ready), .req_addr(a_req_addr),
    .rsp_valid(a_rsp_valid), .rsp_ready(a_rsp_ready), .rsp_instr(a_rsp_instr),
    .rsp_fault(a_rsp_fault), .flush(a_flush),
    .prog_we(a_prog_we), .prog_addr(a_prog_addr), .prog_data(a_prog_data)
  );

  instr_mem_pipelined #(
    .XLEN(XLEN), .DEPTH(B_DEPTH), .READ_LATENCY(4), .BYTE_ADDR(0), .NOP_INSTR(32'h0000_0013)
  ) dut_b (
    .clk(clk), .reset(b_reset),
    .req_valid(b_req_valid), .req_ready(b_req_ready), .req_addr(b_req_addr),
    .rsp_valid(b_rsp_valid), .rsp_ready(b_rsp_ready), .rsp_instr(b_rsp_instr),
    .rsp_fault(b_rsp_fault), .flush(b_flush),
    .prog_we(b_prog_we), .prog_addr(b_prog_addr), .prog_data(b_prog_data)
  );

  // Scoreboard state
  int              total = 0;
  int              bad   = 0;
  logic [XLEN-1:0] exp_q[$];
  logic [XLEN-1:0] data [6];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, got, exp);
    end
  endtask

  // Driver tasks: inputs change 2 time units after the rising edge,
  // outputs are read 1 unit later, well before the next edge.
  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic fetch_a(input logic [31:0] addr);
    a_req_valid = 1'b1;
    a_req_addr  = addr;
    cyc();
    a_req_valid = 1'b0;
    cyc();
    settle();
  endtask

  task automatic fetch_b(input logic [31:0] addr);
    b_req_valid = 1'b1;
    b_req_addr  = addr;
    cyc();
    b_req_valid = 1'b0;
    cyc();
    cyc();
    cyc();
    settle();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int i;
    int popped;
    data = '{32'hA000_0010, 32'hA000_1021, 32'hA000_2032,
             32'hA000_3043, 32'hA000_4054, 32'hA000_5065};
    a_reset = 1'b1; a_req_valid = 1'b0; a_req_addr = '0; a_rsp_ready = 1'b1;
    a_flush = 1'b0; a_prog_we = 1'b0; a_prog_addr = '0; a_prog_data = '0;
    b_reset = 1'b1; b_req_valid = 1'b0; b_req_addr = '0; b_rsp_ready = 1'b1;
    b_flush = 1'b0; b_prog_we = 1'b0; b_prog_addr = '0; b_prog_data = '0;

    // Reset state
    cyc();
    cyc();
    a_reset = 1'b0;
    b_reset = 1'b0;
    settle();
    check("rst_a_valid", 32'(a_rsp_valid), 32'd0);
    check("rst_a_instr", a_rsp_instr, 32'd0);
    check("rst_a_fault", 32'(a_rsp_fault), 32'd0);
    check("rst_a_ready", 32'(a_req_ready), 32'd1);
    check("rst_b_valid", 32'(b_rsp_valid), 32'd0);
    check("rst_b_ready", 32'(b_req_ready), 32'd1);
    cyc();

    // Program load on dut_a
    for (int k = 0; k < 6; k++) begin
      a_prog_we = 1'b1; a_prog_addr = A_AW'(k); a_prog_data = data[k];
      cyc();
    end
    a_prog_addr = 4'd7;  a_prog_data = 32'h7777_7777; cyc();
    a_prog_addr = 4'd15; a_prog_data = 32'h0F0F_1515; cyc();
    a_prog_we = 1'b0;

    // In-order back-to-back fetch, latency 2
    for (int k = 0; k < 9; k++) begin
      a_req_valid = (k < 6);
      a_req_addr  = 32'(k * 4);
      settle();
      if (k < 6) check("seq_ready", 32'(a_req_ready), 32'd1);
      if (k >= 2 && k < 8) begin
        check("seq_valid", 32'(a_rsp_valid), 32'd1);
        check("seq_instr", a_rsp_instr, data[k-2]);
        check("seq_fault", 32'(a_rsp_fault), 32'd0);
      end else begin
        check("seq_idle", 32'(a_rsp_valid), 32'd0);
      end
      cyc();
    end
    a_req_valid = 1'b0;

    // Backpressure: rsp_ready low for cycles 2..4
    i = 0;
    popped = 0;
    for (int k = 0; k < 20; k++) begin
      a_rsp_ready = !(k >= 2 && k <= 4);
      a_req_valid = (i < 6);
      a_req_addr  = 32'(i * 4);
      settle();
      if (k >= 2 && k <= 4) begin
        check("bp_req_ready", 32'(a_req_ready), 32'd0);
        check("bp_valid", 32'(a_rsp_valid), 32'd1);
        check("bp_hold", a_rsp_instr, data[0]);
      end
      if (a_rsp_valid && a_rsp_ready) begin
        total++;
        assert (exp_q.size() != 0) else begin
          bad++;
          $error("FAIL bp_extra: observed=%h expected=no_response", a_rsp_instr);
        end
        if (exp_q.size() != 0) begin
          check("bp_data", a_rsp_instr, exp_q.pop_front());
          popped++;
        end
      end
      if (a_req_valid && a_req_ready) begin
        exp_q.push_back(data[i]);
        i++;
      end
      cyc();
    end
    a_req_valid = 1'b0;
    a_rsp_ready = 1'b1;
    check("bp_count", 32'(popped), 32'd6);
    check("bp_left", 32'(exp_q.size()), 32'd0);

    // Address faults (byte addressing, DEPTH=16)
    fetch_a(32'd6);
    check("f_mis_valid", 32'(a_rsp_valid), 32'd1);
    check("f_mis_instr", a_rsp_instr, 32'h0000_0013);
    check("f_mis_fault", 32'(a_rsp_fault), 32'd1);
    fetch_a(32'd64);
    check("f_rng_instr", a_rsp_instr, 32'h0000_0013);
    check("f_rng_fault", 32'(a_rsp_fault), 32'd2);
    fetch_a(32'd65);
    check("f_both_fault", 32'(a_rsp_fault), 32'd3);
    fetch_a(32'd60);
    check("last_word", a_rsp_instr, 32'h0F0F_1515);
    check("last_fault", 32'(a_rsp_fault), 32'd0);
    fetch_a(32'd32);
    check("unwritten_zero", a_rsp_instr, 32'd0);

    // Same-cycle read and write of word 7
    a_prog_we = 1'b1; a_prog_addr = 4'd7; a_prog_data = 32'hDEAD_BEEF;
    a_req_valid = 1'b1; a_req_addr = 32'd28;
    cyc();
    a_prog_we = 1'b0; a_req_valid = 1'b0;
    cyc();
    settle();
    check("rw_old", a_rsp_instr, 32'h7777_7777);
    fetch_a(32'd28);
    check("rw_new", a_rsp_instr, 32'hDEAD_BEEF);

    // Reset (with flush) while two requests are in flight
    a_req_valid = 1'b1; a_req_addr = 32'd0;
    cyc();
    a_req_addr = 32'd4;
    cyc();
    a_req_valid = 1'b0;
    a_reset = 1'b1;
    a_flush = 1'b1;
    settle();
    check("mrst_pre", a_rsp_instr, data[0]);
    cyc();
    a_reset = 1'b0;
    a_flush = 1'b0;
    settle();
    check("mrst_valid0", 32'(a_rsp_valid), 32'd0);
    check("mrst_instr0", a_rsp_instr, 32'd0);
    check("mrst_ready", 32'(a_req_ready), 32'd1);
    cyc();
    settle();
    check("mrst_valid1", 32'(a_rsp_valid), 32'd0);
    cyc();
    settle();
    check("mrst_valid2", 32'(a_rsp_valid), 32'd0);
    fetch_a(32'd12);
    check("mrst_mem3", a_rsp_instr, data[3]);
    fetch_a(32'd28);
    check("mrst_mem7", a_rsp_instr, 32'hDEAD_BEEF);

    // dut_b program load (word addressing, latency 4)
    for (int k = 0; k < 3; k++) begin
      b_prog_we = 1'b1; b_prog_addr = B_AW'(100 + k); b_prog_data = 32'hB000_0064 + 32'(k);
      cyc();
    end
    b_prog_addr = 11'd1279; b_prog_data = 32'hBEEF_04FF; cyc();
    b_prog_we = 1'b0;

    // Exact latency 4
    b_req_valid = 1'b1; b_req_addr = 32'd100;
    cyc();
    b_req_valid = 1'b0;
    cyc();
    cyc();
    settle();
    check("lat_early", 32'(b_rsp_valid), 32'd0);
    cyc();
    settle();
    check("lat_valid", 32'(b_rsp_valid), 32'd1);
    check("lat_instr", b_rsp_instr, 32'hB000_0064);
    cyc();

    // Flush with three requests in flight
    for (int k = 0; k < 3; k++) begin
      b_req_valid = 1'b1; b_req_addr = 32'(100 + k);
      cyc();
    end
    b_req_addr = 32'd100;
    b_flush = 1'b1;
    settle();
    check("fl_ready", 32'(b_req_ready), 32'd0);
    cyc();
    b_flush = 1'b0;
    b_req_valid = 1'b0;
    for (int m = 0; m < 6; m++) begin
      settle();
      check("fl_quiet", 32'(b_rsp_valid), 32'd0);
      cyc();
    end
    fetch_b(32'd1279);
    check("fl_after", b_rsp_instr, 32'hBEEF_04FF);
    check("fl_after_fault", 32'(b_rsp_fault), 32'd0);
    cyc();
    fetch_b(32'd1280);
    check("b_rng_fault", 32'(b_rsp_fault), 32'd2);
    check("b_rng_instr", b_rsp_instr, 32'h0000_0013);
    cyc();

    // Flush overrides a stalled response
    b_rsp_ready = 1'b0;
    fetch_b(32'd101);
    check("fs_valid", 32'(b_rsp_valid), 32'd1);
    check("fs_instr", b_rsp_instr, 32'hB000_0065);
    check("fs_ready", 32'(b_req_ready), 32'd0);
    b_flush = 1'b1;
    cyc();
    b_flush = 1'b0;
    b_rsp_ready = 1'b1;
    settle();
    check("fs_cleared", 32'(b_rsp_valid), 32'd0);
    cyc();
    fetch_b(32'd102);
    check("fs_next", b_rsp_instr, 32'hB000_0066);

    // Final report
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/instr_mem_pipelined.md
Name: instr_mem_pipelined

Overview:
- Parametrised successor to the current combinational instruction memory.
- Synchronous-read instruction store with a valid/ready request/response handshake, configurable read latency, word or byte addressing, a program-load write port, flush, and fault flagging.
- Sits between the PC/fetch stage and decode; the load port is driven by the testbench or boot loader.

Parameters:
- XLEN, 32, instruction and address width.
- DEPTH, 1280, memory depth in words (>=2).
- READ_LATENCY, 1, accepted request to response valid in cycles, legal 1..4.
- BYTE_ADDR, 0, 0 = req_addr is a word index; 1 = req_addr is a byte address, word = req_addr>>2.
- NOP_INSTR, 32'h00000013, instruction returned on a fault.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  synchronous, active-high.
- req_valid  in  1  fetch request valid.
- req_ready  out  1  block can accept a request.
- req_addr  in  XLEN  fetch address, interpreted per BYTE_ADDR.
- rsp_valid  out  1  response valid.
- rsp_ready  in  1  consumer accepts the response.
- rsp_instr  out  XLEN  fetched instruction.
- rsp_fault  out  2  bit0 = misaligned, bit1 = out of range.
- flush  in  1  discard all in-flight requests.
- prog_we  in  1  program-load write enable.
- prog_addr  in  $clog2(DEPTH)  word index for the write.
- prog_data  in  XLEN  write data.

Behaviour:
- Clock and reset: one clock, clk. reset is synchronous and active-high.
- Storage: DEPTH x XLEN array, all words zero at time 0. reset does not clear memory contents.
- Reset values: rsp_valid=0, rsp_instr=0, rsp_fault=0, all pipeline valid bits=0, req_ready=1 in the cycle after reset deasserts.
- Pipeline: READ_LATENCY stages, each holding {valid, instr, fault}. The array is read in stage 1.
- Accept: a request is accepted when req_valid && req_ready. With no stall, rsp_valid rises exactly READ_LATENCY cycles later.
- Stall: stall = rsp_valid && !rsp_ready.
  - All stages hold while stalled.
  - req_ready = !stall && !flush.
  - rsp_instr and rsp_fault stay stable while stalled.
- Throughput: one request per cycle sustained when rsp_ready=1.
- Address decode:
  - BYTE_ADDR=1 and req_addr[1:0]!=0: fault[0]=1, instr=NOP_INSTR.
  - Word index >= DEPTH: fault[1]=1, instr=NOP_INSTR.
  - Both conditions can be set together.
  - Faulting requests still produce a response with normal latency.
- Program port:
  - prog_we writes on the rising edge regardless of stall or flush.
  - A read and a write to the same word in the same cycle return the OLD data (read-before-write).
  - prog_addr >= DEPTH is ignored.
- Flush:
  - Clears all stage valid bits on the next edge; rsp_valid=0 in the following cycle.
  - req_ready=0 while flush=1, so no request is accepted in a flush cycle.
  - flush overrides stall.
- Reset mid-operation: in-flight requests are dropped with no response; memory is preserved.
- Simultaneous reset and flush: reset wins, and the result is identical to reset alone.

Decomposition:
- Shared package instr_mem_pkg:
  - fault bit indices FAULT_MISALIGN=0, FAULT_RANGE=1.
  - NOP constant.
  - typedef for the {valid, instr, fault} stage struct.
- One sub-module, instr_mem_array: the synchronous-read, single-write array with read-before-write semantics.
- The handshake and pipeline stay in the top module.

Test Plan:
- Load and in-order fetch: prog-load words 0..5, then fetch 0..5 back-to-back with rsp_ready=1 and READ_LATENCY=2 -> six responses in order, first on cycle 2 after the first accept, no gaps, fault=0.
- Backpressure: hold rsp_ready=0 for 3 cycles mid-stream -> req_ready=0, rsp_instr stable, no loss or duplication after release.
- Faults: BYTE_ADDR=1, req_addr=0x6 -> instr=0x00000013, fault=2'b01. req_addr=DEPTH*4 -> fault=2'b10. req_addr=DEPTH*4+1 -> fault=2'b11.
- Read/write same word: same-cycle prog_we to word 7 with 0xDEADBEEF and fetch of 7 -> old value returned; next fetch -> 0xDEADBEEF.
- Flush: flush with 3 requests in flight (READ_LATENCY=4) -> no responses for those requests; a new request after flush returns correct data.
- Reset mid-stream: reset with 2 in flight -> rsp_valid=0 the next cycle, no stale response; memory contents are intact on refetch.
